// File: rtl/mmio_fifo_responder_if.sv
// mmio_fifo_responder_if: CPU-side strobe bus for the FIFO responder.
// master = CPU / bus driver, slave = responder.
interface mmio_fifo_responder_if;
  logic        Select_H;
  logic        AS_L;
  logic        WE_L;
  logic [3:0]  Address;
  logic [3:0]  ByteEnable;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        DTAck_H;
  logic        IRQ_H;

  modport master (
    output Select_H, AS_L, WE_L,
    output Address, ByteEnable, DataIn,
    input  DataOut, DTAck_H, IRQ_H
  );

  modport slave (
    input  Select_H, AS_L, WE_L,
    input  Address, ByteEnable, DataIn,
    output DataOut, DTAck_H, IRQ_H
  );
endinterface

// File: rtl/mmio_fifo_responder.sv
// mmio_fifo_responder: strobe-handshake MMIO slave around a FIFO
// with status, control and threshold-interrupt registers.
module mmio_fifo_responder #(
  parameter int DEPTH      = 16,
  parameter int WAIT_RESET = 2
) (
  input logic                  Clock,
  input logic                  Reset_H,
  mmio_fifo_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACK, S_RELEASE
  } state_t;

  state_t        state;
  logic [2:0]    wcnt;
  logic [1:0]    a_reg;
  logic          a_we_l;
  logic [3:0]    a_be;
  logic [31:0]   a_din;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          udf;
  logic          irq_en;
  logic [2:0]    wait_r;
  logic [7:0]    thresh;
  logic [31:0]   dout;
  logic          dtack;
  logic          irq;

  logic          empty;
  logic          full;
  logic          start;
  logic          gone;
  logic          fire;
  logic          push;
  logic [31:0]   masked;
  logic [31:0]   status;
  logic          addr_unused;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign start  = bus.Select_H & ~bus.AS_L;
  assign gone   = bus.AS_L | ~bus.Select_H;
  assign fire   = (state == S_WAIT) & ~gone
                & (wcnt == 3'd0);
  assign push   = fire & (a_reg == 2'd0)
                & ~a_we_l & ~full;
  assign masked = a_din & {{8{a_be[3]}},
                           {8{a_be[2]}},
                           {8{a_be[1]}},
                           {8{a_be[0]}}};
  assign status = {16'h0, 8'(cnt), 4'h0,
                   udf, ovf, full, empty};
  assign addr_unused = ^bus.Address[1:0];

  assign bus.DataOut = dout;
  assign bus.DTAck_H = dtack;
  assign bus.IRQ_H   = irq;

  // FIFO storage write; contents need no reset
  always_ff @(posedge Clock) begin
    if (!Reset_H && push)
      mem[wp] <= masked;
  end

  // Access FSM, register side effects and interrupt
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      a_reg  <= '0;
      a_we_l <= 1'b1;
      a_be   <= '0;
      a_din  <= '0;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      irq_en <= 1'b0;
      wait_r <= 3'(WAIT_RESET);
      thresh <= '0;
      dout   <= '0;
      dtack  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq <= irq_en
           & ((8'(cnt) >= thresh) | ovf);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_WAIT;
            a_reg  <= bus.Address[3:2];
            a_we_l <= bus.WE_L;
            a_be   <= bus.ByteEnable;
            a_din  <= bus.DataIn;
            wcnt   <= wait_r;
          end
        end
        S_WAIT: begin
          if (gone) begin
            state <= S_IDLE;
          end else if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else begin
            state <= S_ACK;
            dtack <= 1'b1;
            dout  <= '0;
            unique case (a_reg)
              2'd0: begin
                if (!a_we_l) begin
                  if (full) begin
                    ovf <= 1'b1;
                  end else begin
                    wp  <= wp + 1'b1;
                    cnt <= cnt + 1'b1;
                  end
                end else if (empty) begin
                  udf <= 1'b1;
                end else begin
                  dout <= mem[rp];
                  rp   <= rp + 1'b1;
                  cnt  <= cnt - 1'b1;
                end
              end
              2'd1: begin
                if (a_we_l) begin
                  dout <= status;
                end else if (a_be[0]) begin
                  if (a_din[2]) ovf <= 1'b0;
                  if (a_din[3]) udf <= 1'b0;
                end
              end
              2'd2: begin
                if (a_we_l) begin
                  dout <= {28'h0, wait_r, irq_en};
                end else if (a_be[0]) begin
                  irq_en <= a_din[0];
                  wait_r <= a_din[3:1];
                end
              end
              default: begin
                if (a_we_l) begin
                  dout <= {24'h0, thresh};
                end else if (a_be[0]) begin
                  thresh <= a_din[7:0];
                end
              end
            endcase
          end
        end
        S_ACK: begin
          if (gone) begin
            state <= S_RELEASE;
            dtack <= 1'b0;
            dout  <= '0;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_fifo_responder.sv
// tb_mmio_fifo_responder: directed accesses with a scoreboard
// of expected read data checked by an ack monitor.
module tb_mmio_fifo_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mmio_fifo_responder_if bus();

  mmio_fifo_responder #(
    .DEPTH(16),
    .WAIT_RESET(2)
  ) dut (
    .Clock(clk),
    .Reset_H(rst),
    .bus(bus)
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cur_wait = 2;
  bit   mon_on = 0;
  logic prev_ack = 1'b0;
  logic irq_at_ack;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               name, act, exp);
    end
  endtask

  // ack monitor: pops the scoreboard on each DTAck rise
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.DTAck_H && !prev_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack want none");
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.chk)
            check(mon_e.name, bus.DataOut, mon_e.exp);
        end
      end
      if (!bus.DTAck_H)
        check("dout_zero_noack", bus.DataOut, 32'h0);
      prev_ack = bus.DTAck_H;
    end
  end

  task automatic access(input bit wr_en,
                        input logic [3:0] addr,
                        input logic [3:0] be,
                        input logic [31:0] d,
                        input bit chk,
                        input logic [31:0] exp,
                        input string name);
    exp_t e;
    int n;
    e.chk  = chk;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.Select_H   = 1'b1;
    bus.AS_L       = 1'b0;
    bus.WE_L       = ~wr_en;
    bus.Address    = addr;
    bus.ByteEnable = be;
    bus.DataIn     = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.DTAck_H && n < 40);
    irq_at_ack = bus.IRQ_H;
    check({name, "_latency"}, 32'(n),
          32'(cur_wait + 2));
    @(negedge clk);
    bus.AS_L     = 1'b1;
    bus.Select_H = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.DTAck_H && n < 40);
    check({name, "_release"}, 32'(bus.DTAck_H), 32'h0);
    @(posedge clk);
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [3:0] be,
                    input logic [31:0] d,
                    input string nm);
    access(1'b1, a, be, d, 1'b0, 32'h0, nm);
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [31:0] exp,
                    input string nm);
    access(1'b0, a, 4'hF, 32'h0, 1'b1, exp, nm);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.Select_H   = 1'b0;
    bus.AS_L       = 1'b1;
    bus.WE_L       = 1'b1;
    bus.Address    = 4'h0;
    bus.ByteEnable = 4'h0;
    bus.DataIn     = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dtack", 32'(bus.DTAck_H), 32'h0);
    check("rst_irq", 32'(bus.IRQ_H), 32'h0);
    check("rst_dout", bus.DataOut, 32'h0);
    rst = 1'b0;
    mon_on = 1;

    rd(4'h8, 32'h4, "ctrl_reset");
    rd(4'h4, 32'h1, "status_reset");
    rd(4'hC, 32'h0, "thresh_reset");

    wr(4'h0, 4'hF, 32'hDEADBEEF, "push_deadbeef");
    rd(4'h4, 32'h100, "status_one");
    rd(4'h0, 32'hDEADBEEF, "pop_deadbeef");
    rd(4'h7, 32'h1, "status_lowbits");

    wr(4'h8, 4'hF, 32'h0, "ctrl_wait0");
    cur_wait = 0;
    rd(4'h8, 32'h0, "ctrl_read0");

    for (int i = 1; i <= 16; i++)
      wr(4'h0, 4'hF, 32'(i), "fill");
    wr(4'h0, 4'hF, 32'h11, "push_full");
    rd(4'h4, 32'h1006, "status_full_ovf");
    for (int i = 1; i <= 16; i++)
      rd(4'h0, 32'(i), "drain");
    rd(4'h4, 32'h5, "status_ovf_sticky");
    wr(4'h4, 4'hF, 32'h4, "clr_ovf");
    rd(4'h4, 32'h1, "status_ovf_clr");

    rd(4'h0, 32'h0, "pop_empty");
    rd(4'h4, 32'h9, "status_udf");
    wr(4'h4, 4'hF, 32'h8, "clr_udf");
    rd(4'h4, 32'h1, "status_udf_clr");

    wr(4'h0, 4'h5, 32'hAABBCCDD, "push_be0101");
    rd(4'h0, 32'h00BB00DD, "pop_masked");

    wr(4'h8, 4'h0, 32'hF, "ctrl_be0");
    rd(4'h8, 32'h0, "ctrl_unchanged");
    wr(4'hC, 4'h1, 32'h12345603, "thresh3");
    rd(4'hC, 32'h3, "thresh_read");

    wr(4'h8, 4'hF, 32'h1, "irq_en");
    check("irq_idle", 32'(bus.IRQ_H), 32'h0);
    wr(4'h0, 4'hF, 32'hA1, "push_a1");
    wr(4'h0, 4'hF, 32'hA2, "push_a2");
    check("irq_below", 32'(bus.IRQ_H), 32'h0);
    wr(4'h0, 4'hF, 32'hA3, "push_a3");
    check("irq_at_push", 32'(irq_at_ack), 32'h0);
    check("irq_after_push", 32'(bus.IRQ_H), 32'h1);
    rd(4'h0, 32'hA1, "pop_a1");
    check("irq_at_pop", 32'(irq_at_ack), 32'h1);
    check("irq_after_pop", 32'(bus.IRQ_H), 32'h0);
    rd(4'h0, 32'hA2, "pop_a2");
    rd(4'h0, 32'hA3, "pop_a3");
    check("irq_empty", 32'(bus.IRQ_H), 32'h0);
    wr(4'hC, 4'hF, 32'h0, "thresh0");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("irq_thresh0", 32'(bus.IRQ_H), 32'h1);
    end

    wr(4'h8, 4'hF, 32'h6, "ctrl_wait3");
    cur_wait = 3;
    check("irq_disabled", 32'(bus.IRQ_H), 32'h0);

    @(negedge clk);
    bus.Select_H   = 1'b1;
    bus.AS_L       = 1'b0;
    bus.WE_L       = 1'b0;
    bus.Address    = 4'h0;
    bus.ByteEnable = 4'hF;
    bus.DataIn     = 32'h55;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.AS_L     = 1'b1;
    bus.Select_H = 1'b0;
    @(posedge clk);
    #1;
    check("rst_wait_dtack", 32'(bus.DTAck_H), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cur_wait = 2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_wait_noack", 32'(bus.DTAck_H), 32'h0);
    end
    rd(4'h4, 32'h1, "status_after_rst");
    rd(4'h8, 32'h4, "ctrl_after_rst");

    @(negedge clk);
    bus.Select_H   = 1'b1;
    bus.AS_L       = 1'b0;
    bus.WE_L       = 1'b0;
    bus.Address    = 4'h0;
    bus.ByteEnable = 4'hF;
    bus.DataIn     = 32'h77;
    @(posedge clk);
    @(negedge clk);
    bus.AS_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort_noack", 32'(bus.DTAck_H), 32'h0);
    end
    @(negedge clk);
    bus.Select_H = 1'b0;
    rd(4'h4, 32'h1, "status_after_abort");

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_fifo_responder.md
MMIO_FIFO_RESPONDER -- requirements
Module: mmio_fifo_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO entries, a power of two in the range 4..64.
REQ-002 The block SHALL have parameter WAIT_RESET, default 2, the reset value of CTRL.WAIT.
REQ-003 Clock  in  1  system clock; all logic SHALL be rising-edge.
REQ-004 Reset_H  in  1  reset, synchronous, active-high.
REQ-005 Select_H  in  1  from the address decoder; the block is addressed when high.
REQ-006 AS_L  in  1  address strobe, active-low.
REQ-007 WE_L  in  1  0 = write, 1 = read.
REQ-008 Address  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
REQ-009 ByteEnable  in  4  per-lane write enables; bit n covers DataIn[8n+7:8n].
REQ-010 DataIn  in  32  write data from the CPU.
REQ-011 DataOut  out  32  read data; zero whenever DTAck_H is low.
REQ-012 DTAck_H  out  1  transfer acknowledge to the CPU.
REQ-013 IRQ_H  out  1  level interrupt.

Function
REQ-014 The register map SHALL be:
- 0x0 DATA: write pushes; read pops.
- 0x4 STATUS (read):
  - [0] empty
  - [1] full
  - [2] overflow (sticky)
  - [3] underflow (sticky)
  - [15:8] count
- 0x4 STATUS (write): a 1 in bit 2 or bit 3 clears that flag.
- 0x8 CTRL (R/W):
  - [0] irq_en
  - [3:1] WAIT (0..7)
- 0xC THRESH (R/W): [7:0] level.
REQ-015 An access SHALL start when Select_H=1 and AS_L=0 while the FSM is in IDLE.
REQ-016 The FSM SHALL have states IDLE, WAIT, ACK and RELEASE.
REQ-017 IDLE -> WAIT on access start; at that edge the FSM SHALL latch Address[3:2], WE_L, ByteEnable and DataIn, and load the wait counter with CTRL.WAIT.
REQ-018 WAIT SHALL decrement the counter each cycle and go to ACK on the cycle the counter equals 0; with WAIT=0 the FSM spends exactly one cycle in WAIT.
REQ-019 On the WAIT->ACK edge the FSM SHALL perform the register side effect (push, pop, CSR update) exactly once per access.
REQ-020 ACK SHALL drive DTAck_H=1 and hold DataOut stable; it SHALL go to RELEASE when AS_L=1 or Select_H=0.
REQ-021 RELEASE SHALL drive DTAck_H=0 for one cycle, then go to IDLE; a new access is not accepted in RELEASE.
REQ-022 Latency from access start to DTAck_H high SHALL be CTRL.WAIT+2 cycles.
REQ-023 A DATA write SHALL push DataIn with byte lanes whose ByteEnable bit is 0 forced to 0x00.
REQ-024 A push when full SHALL be dropped and set overflow; count and contents are unchanged.
REQ-025 A pop when empty SHALL return 0x00000000 and set underflow; count stays 0.
REQ-026 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 Count SHALL be log2(DEPTH)+1 bits, zero-extended into STATUS[15:8].
REQ-028 Writes to CTRL and THRESH SHALL honour ByteEnable; unused bits read as 0.
REQ-029 A CTRL.WAIT write SHALL take effect from the next access.
REQ-030 IRQ_H SHALL be registered and equal irq_en AND (count >= THRESH OR overflow).
REQ-031 With THRESH=0 and irq_en=1, IRQ_H SHALL be 1 continuously.
REQ-032 An access that ends early (AS_L high during WAIT) SHALL abort: no side effect, return to IDLE, DTAck_H never asserted.
REQ-033 A read of DATA SHALL capture the head entry at the pop edge; DataOut is registered.

Reset
REQ-034 While Reset_H=1 at a rising edge the block SHALL set:
- FSM to IDLE
- pointers, count and flags to 0
- CTRL to {WAIT_RESET, irq_en=0}
- THRESH to 0
- DTAck_H, IRQ_H and DataOut to 0
REQ-035 Reset SHALL override an in-progress access; the interrupted access has no side effect.
REQ-036 FIFO storage contents SHALL NOT require reset.

Verification
REQ-037 Write DATA 0xDEADBEEF, BE=1111, WAIT=2 -> DTAck_H high 4 cycles after strobe; STATUS reads 0x00000100.
REQ-038 Push 0x1..0x10 (DEPTH=16), then push 0x11 -> STATUS=0x00001006; 16 pops return 0x1..0x10 in order.
REQ-039 Pop when empty -> DataOut=0x00000000 and STATUS=0x00000009; write STATUS 0x8 -> STATUS=0x00000001.
REQ-040 Write DATA 0xAABBCCDD, BE=0101 -> the pop returns 0x00BB00DD.
REQ-041 THRESH=3, irq_en=1, push 3 words -> IRQ_H rises 1 cycle after the third push edge; one pop -> IRQ_H falls.
REQ-042 Assert Reset_H during WAIT of a DATA write -> count stays 0, DTAck_H stays 0, CTRL reads 0x00000004.
